// File: rtl/commit_trace_fifo.sv
// Multi-lane retire trace FIFO with retire/cycle counters and end-of-sim / timeout detection.
// Optional macro COMMIT_TRACE_STORE_EN: retired stores are also enqueued as trace records.
module commit_trace_fifo #(
    parameter int          COMMIT_W  = 2,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] END_ADDR  = 32'h0001_FFFC,
    parameter logic [31:0] END_CODE  = 32'hFFFF_FFFF,
    parameter int          MAX_CYCLE = 500000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COMMIT_W-1:0]    commit_valid,
    input  logic [32*COMMIT_W-1:0] commit_pc,
    input  logic [32*COMMIT_W-1:0] commit_inst,
    input  logic [6*COMMIT_W-1:0]  commit_ard,
    input  logic [32*COMMIT_W-1:0] commit_data,
    input  logic                   st_commit,
    input  logic [31:0]            st_addr,
    input  logic [31:0]            st_data,
    output logic                   trace_valid,
    input  logic                   trace_ready,
    output logic [31:0]            trace_pc,
    output logic [31:0]            trace_inst,
    output logic [31:0]            trace_data,
    output logic [5:0]             trace_ard,
    output logic                   trace_is_store,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic [63:0]            retired_count,
    output logic [63:0]            total_cycle,
    output logic                   sim_done,
    output logic                   sim_timeout
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [63:0]   LAST_CYCLE = 64'(MAX_CYCLE - 1);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [5:0]  ard_mem  [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, done_q, done_d, tmo_q, tmo_d;
    logic [15:0]   drop_q, drop_d;
    logic [63:0]   retired_q, retired_d, cycle_q, cycle_d;

    logic [PW-1:0] lane_slot [COMMIT_W];
    logic [CW-1:0] n_lanes, n_push;
    logic          end_hit, fits, do_push, do_drop, do_pop;

    // Sparse lanes are compacted: each valid lane lands after all older valid lanes.
    always_comb begin
        n_lanes = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_slot[i] = wr_ptr_q + PW'(n_lanes);
            n_lanes      = n_lanes + CW'(commit_valid[i]);
        end
    end

`ifdef COMMIT_TRACE_STORE_EN
    logic st_mem [DEPTH];
    assign n_push         = n_lanes + CW'(st_commit);
    assign trace_is_store = st_mem[rd_ptr_q];
`else
    assign n_push         = n_lanes;
    assign trace_is_store = 1'b0;
`endif

    assign end_hit = st_commit && (st_addr == END_ADDR) && (st_data == END_CODE);
    assign do_pop  = (count_q != '0) && trace_ready;
    // Space is judged on start-of-cycle occupancy; a simultaneous pop earns no credit.
    assign fits    = n_push <= (DEPTH_C - count_q);
    assign do_push = (state_q == ST_RUN) && (n_push != '0) && fits;
    assign do_drop = (state_q == ST_RUN) && (n_push != '0) && !fits;

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        wr_ptr_d  = do_push ? wr_ptr_q + PW'(n_push) : wr_ptr_q;
        rd_ptr_d  = rd_ptr_q + PW'(do_pop);
        count_d   = count_q + (do_push ? n_push : '0) - CW'(do_pop);
        retired_d = retired_q + (do_push ? 64'(n_lanes) : 64'd0);
        ovf_d     = ovf_q | do_drop;
        drop_d    = do_drop ? sat_add16(drop_q, n_push) : drop_q;
        cycle_d   = cycle_q + 64'd1;
        case (state_q)
            ST_RUN: begin
                if (end_hit) begin
                    state_d = ST_DRAIN;
                end else if (cycle_q == LAST_CYCLE) begin
                    state_d = ST_TIMEOUT;
                    tmo_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
            retired_q <= '0;
            cycle_q   <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
            retired_q <= retired_d;
            cycle_q   <= cycle_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (commit_valid[i]) begin
                    pc_mem[lane_slot[i]]   <= commit_pc[32*i +: 32];
                    inst_mem[lane_slot[i]] <= commit_inst[32*i +: 32];
                    data_mem[lane_slot[i]] <= commit_data[32*i +: 32];
                    ard_mem[lane_slot[i]]  <= commit_ard[6*i +: 6];
`ifdef COMMIT_TRACE_STORE_EN
                    st_mem[lane_slot[i]]   <= 1'b0;
`endif
                end
            end
`ifdef COMMIT_TRACE_STORE_EN
            if (st_commit) begin
                pc_mem[wr_ptr_q + PW'(n_lanes)]   <= st_addr;
                inst_mem[wr_ptr_q + PW'(n_lanes)] <= 32'd0;
                data_mem[wr_ptr_q + PW'(n_lanes)] <= st_data;
                ard_mem[wr_ptr_q + PW'(n_lanes)]  <= 6'd0;
                st_mem[wr_ptr_q + PW'(n_lanes)]   <= 1'b1;
            end
`endif
        end
    end

    assign trace_valid   = (count_q != '0);
    assign trace_pc      = pc_mem[rd_ptr_q];
    assign trace_inst    = inst_mem[rd_ptr_q];
    assign trace_data    = data_mem[rd_ptr_q];
    assign trace_ard     = ard_mem[rd_ptr_q];
    assign fifo_count    = count_q;
    assign overflow      = ovf_q;
    assign drop_count    = drop_q;
    assign retired_count = retired_q;
    assign total_cycle   = cycle_q;
    assign sim_done      = done_q;
    assign sim_timeout   = tmo_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: directed scenarios plus randomized traffic against a queue-based model.
// Honours COMMIT_TRACE_STORE_EN when the design is built with it.
`timescale 1ns/1ps
module tb_commit_trace_fifo;
    localparam int W = 2, D = 16, MAXC = 60000;
    localparam logic [31:0] EADDR = 32'h0001_FFFC, ECODE = 32'hFFFF_FFFF;
`ifdef COMMIT_TRACE_STORE_EN
    localparam bit STORE_EN = 1'b1;
`else
    localparam bit STORE_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [W-1:0] commit_valid = '0;
    logic [32*W-1:0] commit_pc = '0, commit_inst = '0, commit_data = '0;
    logic [6*W-1:0] commit_ard = '0;
    logic st_commit = 1'b0, trace_ready = 1'b0;
    logic [31:0] st_addr = '0, st_data = '0;

    logic trace_valid, trace_is_store, overflow, sim_done, sim_timeout;
    logic [31:0] trace_pc, trace_inst, trace_data;
    logic [5:0] trace_ard;
    logic [4:0] fifo_count;
    logic [15:0] drop_count;
    logic [63:0] retired_count, total_cycle;

    logic to_valid, to_is_store, to_ovf, to_done, to_tmo;
    logic [31:0] to_pc, to_inst, to_data;
    logic [5:0] to_ard;
    logic [4:0] to_count;
    logic [15:0] to_drop;
    logic [63:0] to_retired, to_total;

    int nvec = 0, nerr = 0;

    commit_trace_fifo #(.COMMIT_W(W), .DEPTH(D), .END_ADDR(EADDR), .END_CODE(ECODE), .MAX_CYCLE(MAXC)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_ard(commit_ard), .commit_data(commit_data), .st_commit(st_commit), .st_addr(st_addr),
        .st_data(st_data), .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_inst(trace_inst), .trace_data(trace_data), .trace_ard(trace_ard), .trace_is_store(trace_is_store),
        .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count), .retired_count(retired_count),
        .total_cycle(total_cycle), .sim_done(sim_done), .sim_timeout(sim_timeout));

    commit_trace_fifo #(.COMMIT_W(W), .DEPTH(D), .END_ADDR(EADDR), .END_CODE(ECODE), .MAX_CYCLE(20)) dut_to (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_ard(commit_ard), .commit_data(commit_data), .st_commit(st_commit), .st_addr(st_addr),
        .st_data(st_data), .trace_valid(to_valid), .trace_ready(trace_ready), .trace_pc(to_pc),
        .trace_inst(to_inst), .trace_data(to_data), .trace_ard(to_ard), .trace_is_store(to_is_store),
        .fifo_count(to_count), .overflow(to_ovf), .drop_count(to_drop), .retired_count(to_retired),
        .total_cycle(to_total), .sim_done(to_done), .sim_timeout(to_tmo));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, inst, data;
        logic [5:0]  ard;
        logic        is_store;
    } ent_t;

    ent_t mq[$];
    int m_state;  // 0 run, 1 drain, 2 done, 3 timeout
    longint unsigned m_ret, m_cyc;
    int m_drop;
    bit m_ovf, m_done, m_tmo;

    task automatic model_reset();
        mq.delete();
        m_state = 0; m_ret = 0; m_cyc = 0; m_drop = 0;
        m_ovf = 0; m_done = 0; m_tmo = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_tick();
        int n, ntot, pre;
        ent_t e;
        pre = mq.size();
        n = 0;
        for (int i = 0; i < W; i++) if (commit_valid[i]) n++;
        ntot = n + ((STORE_EN && st_commit) ? 1 : 0);
        if (pre != 0 && trace_ready) e = mq.pop_front();
        if (m_state == 0 && ntot > 0) begin
            if (ntot <= D - pre) begin
                for (int i = 0; i < W; i++) begin
                    if (commit_valid[i]) begin
                        e.pc = commit_pc[32*i +: 32]; e.inst = commit_inst[32*i +: 32];
                        e.data = commit_data[32*i +: 32]; e.ard = commit_ard[6*i +: 6]; e.is_store = 0;
                        mq.push_back(e);
                    end
                end
                if (STORE_EN && st_commit) begin
                    e.pc = st_addr; e.inst = 0; e.data = st_data; e.ard = 0; e.is_store = 1;
                    mq.push_back(e);
                end
                m_ret += longint'(n);
            end else begin
                m_ovf = 1;
                m_drop = (m_drop + ntot > 65535) ? 65535 : m_drop + ntot;
            end
        end
        if (m_state == 0) begin
            if (st_commit && st_addr == EADDR && st_data == ECODE) m_state = 1;
            else if (m_cyc == MAXC - 1) begin m_state = 3; m_tmo = 1; end
        end else if (m_state == 1 && pre == 0) begin
            m_state = 2; m_done = 1;
        end
        m_cyc++;
    endtask

    task automatic cyc();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        commit_valid = '0; commit_pc = '0; commit_inst = '0; commit_data = '0; commit_ard = '0;
        st_commit = 0; st_addr = '0; st_data = '0; trace_ready = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (trace_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", trace_valid); end
        nvec++; if (fifo_count !== 5'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        nvec++; if ({overflow, sim_done, sim_timeout} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b want 000", {overflow, sim_done, sim_timeout}); end
        nvec++; if (drop_count !== 16'd0 || retired_count !== 64'd0 || total_cycle !== 64'd0) begin
            nerr++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", drop_count, retired_count, total_cycle); end
        nvec++; if (trace_is_store !== 1'b0) begin nerr++; $display("FAIL reset_is_store got %b want 0", trace_is_store); end
    endtask

    task automatic test_dual();
        do_reset();
        trace_ready = 1; commit_valid = 2'b11; commit_pc = {32'h104, 32'h100};
        cyc();
        nvec++; if (trace_pc !== 32'h100) begin nerr++; $display("FAIL dual_head0 got %h want 100", trace_pc); end
        nvec++; if (fifo_count !== 5'd2) begin nerr++; $display("FAIL dual_count got %0d want 2", fifo_count); end
        commit_valid = 0;
        cyc();
        nvec++; if (trace_pc !== 32'h104 || trace_valid !== 1'b1) begin nerr++; $display("FAIL dual_head1 got %h/%b want 104/1", trace_pc, trace_valid); end
        nvec++; if (retired_count !== 64'd2) begin nerr++; $display("FAIL dual_retired got %0d want 2", retired_count); end
        cyc();
        nvec++; if (fifo_count !== 5'd0 || trace_valid !== 1'b0) begin nerr++; $display("FAIL dual_empty got %0d/%b want 0/0", fifo_count, trace_valid); end
    endtask

    task automatic test_sparse();
        do_reset();
        commit_valid = 2'b10; commit_pc = {32'h200, 32'hDEAD};
        cyc();
        commit_valid = 0;
        nvec++; if (fifo_count !== 5'd1) begin nerr++; $display("FAIL sparse_count got %0d want 1", fifo_count); end
        nvec++; if (trace_pc !== 32'h200) begin nerr++; $display("FAIL sparse_head got %h want 200", trace_pc); end
        nvec++; if (retired_count !== 64'd1) begin nerr++; $display("FAIL sparse_retired got %0d want 1", retired_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            commit_valid = 2'b11; commit_pc = {32'(k * 8 + 4), 32'(k * 8)};
            cyc();
        end
        nvec++; if (fifo_count !== 5'd16 || overflow !== 1'b0) begin nerr++; $display("FAIL ovf_fill got %0d/%b want 16/0", fifo_count, overflow); end
        cyc();
        nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag got %b want 1", overflow); end
        nvec++; if (drop_count !== 16'd2) begin nerr++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
        nvec++; if (fifo_count !== 5'd16 || retired_count !== 64'd16) begin nerr++; $display("FAIL ovf_hold got %0d/%0d want 16/16", fifo_count, retired_count); end
        commit_valid = 2'b01; trace_ready = 1;
        cyc();
        nvec++; if (fifo_count !== 5'd15 || drop_count !== 16'd3) begin nerr++; $display("FAIL ovf_nocredit got %0d/%0d want 15/3", fifo_count, drop_count); end
        cyc();
        nvec++; if (fifo_count !== 5'd15 || retired_count !== 64'd17) begin nerr++; $display("FAIL ovf_pushpop got %0d/%0d want 15/17", fifo_count, retired_count); end
        nvec++; if (trace_pc !== 32'd8) begin nerr++; $display("FAIL ovf_head got %h want 8", trace_pc); end
        drive_idle();
    endtask

    task automatic test_endsim();
        int nq;
        nq = STORE_EN ? 4 : 3;
        do_reset();
        commit_valid = 2'b11; commit_pc = {32'h104, 32'h100};
        cyc();
        commit_valid = 2'b01; commit_pc = {32'h0, 32'h108};
        st_commit = 1; st_addr = EADDR; st_data = ECODE;
        cyc();
        nvec++; if (fifo_count !== 5'(nq) || retired_count !== 64'd3) begin nerr++; $display("FAIL end_capture got %0d/%0d want %0d/3", fifo_count, retired_count, nq); end
        st_commit = 0; commit_valid = 2'b11;
        cyc();
        nvec++; if (fifo_count !== 5'(nq) || retired_count !== 64'd3) begin nerr++; $display("FAIL end_nocapture got %0d/%0d want %0d/3", fifo_count, retired_count, nq); end
        trace_ready = 1;
        for (int k = 1; k <= nq; k++) begin
            cyc();
            nvec++; if (fifo_count !== 5'(nq - k) || sim_done !== 1'b0) begin nerr++; $display("FAIL end_drain%0d got %0d/%b want %0d/0", k, fifo_count, sim_done, nq - k); end
            if (k == 1) begin
                nvec++; if (trace_pc !== 32'h104) begin nerr++; $display("FAIL end_head got %h want 104", trace_pc); end
            end
        end
        cyc();
        nvec++; if (sim_done !== 1'b1 || fifo_count !== 5'd0) begin nerr++; $display("FAIL end_done got %b/%0d want 1/0", sim_done, fifo_count); end
        drive_idle();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int e = 1; e <= 19; e++) begin
            commit_valid = (e == 5) ? 2'b01 : 2'b00;
            commit_pc = {32'h0, 32'h500};
            cyc();
        end
        commit_valid = 0;
        nvec++; if (to_total !== 64'd19 || to_tmo !== 1'b0 || to_count !== 5'd1) begin nerr++; $display("FAIL tmo_pre got %0d/%b/%0d want 19/0/1", to_total, to_tmo, to_count); end
        cyc();
        nvec++; if (to_tmo !== 1'b1 || to_total !== 64'd20) begin nerr++; $display("FAIL tmo_set got %b/%0d want 1/20", to_tmo, to_total); end
        commit_valid = 2'b11;
        repeat (3) cyc();
        nvec++; if (to_count !== 5'd1 || to_retired !== 64'd1) begin nerr++; $display("FAIL tmo_ignore got %0d/%0d want 1/1", to_count, to_retired); end
        trace_ready = 1;
        cyc();
        nvec++; if (to_count !== 5'd0 || to_done !== 1'b0) begin nerr++; $display("FAIL tmo_drain got %0d/%b want 0/0", to_count, to_done); end
        drive_idle();
    endtask

    task automatic test_store();
        do_reset();
        commit_valid = 2'b01; commit_pc = {32'h0, 32'h300};
        st_commit = 1; st_addr = 32'h8000; st_data = 32'h55;
        cyc();
        drive_idle();
        nvec++; if (trace_pc !== 32'h300 || trace_is_store !== 1'b0) begin nerr++; $display("FAIL store_first got %h/%b want 300/0", trace_pc, trace_is_store); end
        nvec++; if (fifo_count !== 5'(STORE_EN ? 2 : 1)) begin nerr++; $display("FAIL store_count got %0d want %0d", fifo_count, STORE_EN ? 2 : 1); end
`ifdef COMMIT_TRACE_STORE_EN
        trace_ready = 1;
        cyc();
        trace_ready = 0;
        nvec++; if ({trace_pc, trace_data, trace_inst} !== {32'h8000, 32'h55, 32'h0} || trace_ard !== 6'd0 || trace_is_store !== 1'b1) begin
            nerr++; $display("FAIL store_rec got %h/%h/%h/%0d/%b want 8000/55/0/0/1", trace_pc, trace_data, trace_inst, trace_ard, trace_is_store); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        commit_valid = 2'b11;
        repeat (3) cyc();
        commit_valid = 0;
        #2 rst = 1;
        #1;
        nvec++; if (fifo_count !== 5'd0 || trace_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_fifo got %0d/%b want 0/0", fifo_count, trace_valid); end
        nvec++; if (retired_count !== 64'd0 || total_cycle !== 64'd0) begin nerr++; $display("FAIL rstmid_cnt got %0d/%0d want 0/0", retired_count, total_cycle); end
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            commit_valid = W'($urandom);
            commit_pc = {$urandom, $urandom}; commit_inst = {$urandom, $urandom};
            commit_data = {$urandom, $urandom}; commit_ard = 12'($urandom);
            st_commit = ($urandom_range(0, 9) == 0);
            st_addr = {16'h0, 16'($urandom)}; st_data = $urandom;
            trace_ready = ($urandom_range(0, 9) < 4);
            cyc();
            nvec++; if (fifo_count !== 5'(mq.size()) || trace_valid !== (mq.size() != 0)) begin
                nerr++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, fifo_count, mq.size()); end
            if (mq.size() != 0) begin
                nvec++; if ({trace_pc, trace_inst, trace_data, trace_ard, trace_is_store} !== {mq[0].pc, mq[0].inst, mq[0].data, mq[0].ard, mq[0].is_store}) begin
                    nerr++; $display("FAIL rnd_head c=%0d got %h/%h/%h want %h/%h/%h", c, trace_pc, trace_inst, trace_data, mq[0].pc, mq[0].inst, mq[0].data); end
            end
            nvec++; if (retired_count !== m_ret || drop_count !== 16'(m_drop) || overflow !== m_ovf || total_cycle !== m_cyc) begin
                nerr++; $display("FAIL rnd_stats c=%0d got %0d/%0d/%b/%0d want %0d/%0d/%b/%0d", c, retired_count, drop_count, overflow, total_cycle, m_ret, m_drop, m_ovf, m_cyc); end
        end
        st_commit = 1; st_addr = EADDR; st_data = ECODE; commit_valid = W'($urandom);
        cyc();
        st_commit = 0;
        for (int c = 0; c < 40; c++) begin
            commit_valid = W'($urandom); trace_ready = 1;
            cyc();
            nvec++; if (fifo_count !== 5'(mq.size()) || sim_done !== m_done) begin
                nerr++; $display("FAIL rnd_drain c=%0d got %0d/%b want %0d/%b", c, fifo_count, sim_done, mq.size(), m_done); end
        end
        nvec++; if (sim_done !== 1'b1) begin nerr++; $display("FAIL rnd_done got %b want 1", sim_done); end
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dual();
        test_sparse();
        test_overflow();
        test_endsim();
        test_timeout();
        test_store();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
